// File: rtl/pc_keyboard_if.sv
// XT keyboard serial receiver feeding 8255 port A; raises IRQ1 and holds the code until PB7 clears it.
// Optional KBD_TIMEOUT_EN: discard a partial frame after TIMEOUT_CYCLES clocks without a keyboard clock edge.
module pc_keyboard_if #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kbd_clk,
    input  logic       kbd_data,
    input  logic       kbd_clk_en,
    input  logic       clr_kbd,
    output logic [7:0] scancode,
    output logic       irq1,
    output logic       kbd_clk_pull,
    output logic       kbd_data_pull
);
    typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev, fall, bit_s;
    logic [7:0]             shreg, shreg_nx, code_nx;
    logic [2:0]             bitcnt, bitcnt_nx;
    logic                   irq_nx;

    // Synchronizers idle high, matching an idle open-drain line.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
            fall      <= 1'b0;
            bit_s     <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], kbd_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], kbd_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
            fall      <= clk_prev & ~clk_sync[SYNC_STAGES-1];
            bit_s     <= data_sync[SYNC_STAGES-1];
        end
    end

`ifdef KBD_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo, tmo_nx;
`endif

    always_comb begin
        state_nx  = state;
        shreg_nx  = shreg;
        bitcnt_nx = bitcnt;
        code_nx   = scancode;
        irq_nx    = irq1;
`ifdef KBD_TIMEOUT_EN
        tmo_nx    = tmo;
`endif
        if (clr_kbd) begin
            state_nx  = IDLE;
            shreg_nx  = 8'h00;
            bitcnt_nx = 3'd0;
            code_nx   = 8'h00;
            irq_nx    = 1'b0;
`ifdef KBD_TIMEOUT_EN
            tmo_nx    = '0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef KBD_TIMEOUT_EN
                    tmo_nx = '0;
`endif
                    // A zero start bit is treated as line noise.
                    if (fall && bit_s) begin
                        state_nx  = SHIFT;
                        bitcnt_nx = 3'd0;
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        shreg_nx  = {bit_s, shreg[7:1]};
                        bitcnt_nx = bitcnt + 3'd1;
`ifdef KBD_TIMEOUT_EN
                        tmo_nx    = '0;
`endif
                        if (bitcnt == 3'd7) begin
                            code_nx  = {bit_s, shreg[7:1]};
                            irq_nx   = 1'b1;
                            state_nx = FULL;
                        end
                    end
`ifdef KBD_TIMEOUT_EN
                    else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_nx  = IDLE;
                        shreg_nx  = 8'h00;
                        bitcnt_nx = 3'd0;
                        tmo_nx    = '0;
                    end else begin
                        tmo_nx = tmo + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            shreg         <= 8'h00;
            bitcnt        <= 3'd0;
            scancode      <= 8'h00;
            irq1          <= 1'b0;
            kbd_clk_pull  <= 1'b0;
            kbd_data_pull <= 1'b0;
`ifdef KBD_TIMEOUT_EN
            tmo           <= '0;
`endif
        end else begin
            state         <= state_nx;
            shreg         <= shreg_nx;
            bitcnt        <= bitcnt_nx;
            scancode      <= code_nx;
            irq1          <= irq_nx;
            kbd_clk_pull  <= ~kbd_clk_en;
            kbd_data_pull <= clr_kbd | (state_nx == FULL);
`ifdef KBD_TIMEOUT_EN
            tmo           <= tmo_nx;
`endif
        end
    end
endmodule

// File: tb/tb_pc_keyboard_if.sv
// Randomized bench for pc_keyboard_if: a frame-level model fills a scoreboard that a monitor drains on each irq1 rise.
module tb_pc_keyboard_if;
    localparam int SYNC = 2;
    localparam int TMO  = 4096;

    logic       clk = 1'b0;
    logic       reset, kbd_clk, kbd_data, kbd_clk_en, clr_kbd;
    logic [7:0] scancode;
    logic       irq1, kbd_clk_pull, kbd_data_pull;

    pc_keyboard_if #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .kbd_clk(kbd_clk), .kbd_data(kbd_data),
        .kbd_clk_en(kbd_clk_en), .clr_kbd(clr_kbd), .scancode(scancode),
        .irq1(irq1), .kbd_clk_pull(kbd_clk_pull), .kbd_data_pull(kbd_data_pull)
    );

    always #5 clk = ~clk;

    int   vectors = 0, miscompares = 0;
    int   cyc = 0;
    always @(posedge clk) cyc++;

    // Reference model: bits collected since a valid start bit, plus the held code.
    bit       frame_q[$];
    logic [7:0] exp_q[$];
    bit       model_full = 0;
    logic [7:0] model_code = 8'h00;
    int       last_edge = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit d);
        int b;
        if (model_full) return;
`ifdef KBD_TIMEOUT_EN
        if (frame_q.size() > 0 && (cyc - last_edge) >= TMO) frame_q.delete();
`endif
        last_edge = cyc;
        if (frame_q.size() == 0) begin
            if (d) frame_q.push_back(1'b1);
        end else begin
            frame_q.push_back(d);
            if (frame_q.size() == 9) begin
                b = 0;
                for (int i = 1; i <= 8; i++) b += int'(frame_q[i]) << (i - 1);
                model_code = 8'(b);
                model_full = 1;
                exp_q.push_back(model_code);
                frame_q.delete();
            end
        end
    endtask

    task automatic model_clear();
        frame_q.delete();
        model_full = 0;
        model_code = 8'h00;
    endtask

    task automatic edge_bit(input bit d, input int half, input bit do_model);
        kbd_data = d;
        repeat (half) @(negedge clk);
        kbd_clk = 1'b0;
        if (do_model) model_edge(d);
        repeat (half) @(negedge clk);
        kbd_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int half);
        edge_bit(1'b1, half, 1'b1);
        for (int i = 0; i < 8; i++) edge_bit(b[i], half, 1'b1);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_kbd = 1'b1;
        model_clear();
        @(negedge clk);
        clr_kbd = 1'b0;
    endtask

    task automatic check_state(input string tag);
        repeat (SYNC + 4) @(negedge clk);
        check({tag, "_code"}, scancode, model_code);
        check({tag, "_irq"}, irq1, model_full);
        check({tag, "_dpull"}, kbd_data_pull, model_full);
    endtask

    // Monitor: every irq1 rise must match the oldest expected byte.
    bit irq_q = 0;
    always @(negedge clk) begin
        if (!reset && irq1 && !irq_q) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: got %0h, expected no byte", scancode);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (scancode !== e) begin
                    miscompares++;
                    $display("FAIL sb_byte: got %0h, expected %0h", scancode, e);
                end
            end
        end
        irq_q = reset ? 1'b0 : irq1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; kbd_clk = 1; kbd_data = 1; kbd_clk_en = 1; clr_kbd = 0;
        repeat (5) @(negedge clk);
        check("rst_code", scancode, 8'h00);
        check("rst_irq", irq1, 1'b0);
        check("rst_cpull", kbd_clk_pull, 1'b0);
        check("rst_dpull", kbd_data_pull, 1'b0);
        reset = 0;

        // 0x1E with exact completion latency on the final bit.
        edge_bit(1'b1, 50, 1'b1);
        for (int i = 0; i < 7; i++) edge_bit(((8'h1E >> i) & 1) != 0, 50, 1'b1);
        kbd_data = 1'b0;
        repeat (50) @(negedge clk);
        kbd_clk = 1'b0;
        model_edge(1'b0);
        repeat (SYNC + 1) @(negedge clk);
        check("lat_early_irq", irq1, 1'b0);
        @(negedge clk);
        check("lat_irq", irq1, 1'b1);
        check("lat_code", scancode, 8'h1E);
        repeat (49 - SYNC - 2) @(negedge clk);
        kbd_clk = 1'b1;
        check_state("f1e");

        // Ignored while full, then clear and resend.
        send_frame(8'h9E, 50);
        check_state("full_hold");
        pulse_clr();
        check("clr_irq", irq1, 1'b0);
        check("clr_code", scancode, 8'h00);
        @(negedge clk);
        check("clr_dpull", kbd_data_pull, 1'b0);
        send_frame(8'h9E, 50);
        check_state("f9e");
        pulse_clr();

        // Zero start bit is rejected.
        edge_bit(1'b0, 50, 1'b1);
        send_frame(8'h2A, 50);
        check_state("glitch");
        pulse_clr();

        // Partial frame, long idle, then a full frame.
        edge_bit(1'b1, 50, 1'b1);
        edge_bit(1'b1, 50, 1'b1);
        edge_bit(1'b0, 50, 1'b1);
        edge_bit(1'b1, 50, 1'b1);
        edge_bit(1'b0, 50, 1'b1);
        repeat (5000) @(negedge clk);
        send_frame(8'h1C, 50);
        check_state("timeout");
`ifdef KBD_TIMEOUT_EN
        check("tmo_1c", scancode, 8'h1C);
`else
        vectors++;
        if (scancode === 8'h1C) begin
            miscompares++;
            $display("FAIL no_tmo: got %0h, expected not 1c", scancode);
        end
`endif
        pulse_clr();

        // Keyboard clock inhibit.
        kbd_clk_en = 1'b0;
        @(negedge clk);
        check("cpull_on", kbd_clk_pull, 1'b1);
        kbd_clk_en = 1'b1;
        @(negedge clk);
        check("cpull_off", kbd_clk_pull, 1'b0);

        // clr_kbd held across the completing edge wins.
        edge_bit(1'b1, 30, 1'b1);
        for (int i = 0; i < 7; i++) edge_bit(1'b1, 30, 1'b1);
        kbd_data = 1'b1;
        repeat (30) @(negedge clk);
        kbd_clk = 1'b0;
        clr_kbd = 1'b1;
        model_clear();
        repeat (SYNC + 2) @(negedge clk);
        check("clr_hold_dpull", kbd_data_pull, 1'b1);
        repeat (4) @(negedge clk);
        clr_kbd = 1'b0;
        repeat (30) @(negedge clk);
        kbd_clk = 1'b1;
        check_state("clr_race");

        // Reset mid-frame.
        edge_bit(1'b1, 40, 1'b1);
        for (int i = 0; i < 5; i++) edge_bit(i[0], 40, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        check("mrst_code", scancode, 8'h00);
        check("mrst_irq", irq1, 1'b0);
        check("mrst_dpull", kbd_data_pull, 1'b0);
        reset = 1'b0;
        send_frame(8'h01, 40);
        check_state("f01");
        pulse_clr();

        // Random frames, glitches and skipped clears.
        for (int n = 0; n < 24; n++) begin
            int half;
            half = $urandom_range(10, 40);
            if ($urandom_range(0, 3) == 0) edge_bit(1'b0, half, 1'b1);
            send_frame(8'($urandom), half);
            check_state("rnd");
            if ($urandom_range(0, 2) != 0) pulse_clr();
        end

        repeat (10) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
